freq_meter_mc: RTL

FREQ_METER_MC -- requirements
Module: freq_meter_mc

---
 rtl/freq_meter_mc.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/freq_meter_mc.sv
// rtl/freq_meter_mc.sv - multi-channel edge-gated frequency meter (optional FREQ_METER_TIMEOUT_EN edge timeout)
module freq_meter_mc #(
  parameter int NCH    = 4,
  parameter int CW     = 32,
  parameter int TO_LEN = 1000000,
  localparam int SW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic [NCH-1:0] sig_in,
  input  logic [SW-1:0]  ch_sel,
  input  logic [CW-1:0]  gate_len,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0]  sig_cnt,
  output logic [CW-1:0]  ref_cnt,
  output logic [SW-1:0]  res_ch,
  output logic          overflow,
  output logic          timeout
);

  typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t          state;
  logic [NCH-1:0]  sync1, sync2, edge_q;
  logic [NCH-1:0]  edge_vec;
  logic [SW-1:0]   ch_q;
  logic [CW-1:0]   gl_q;
  logic [CW-1:0]   ref_nx;
  logic            sel_pulse;
  logic            to_hit;

  // Two-flop synchronizer followed by an edge register per channel
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      edge_q <= '0;
    end else begin
      sync1  <= sig_in;
      sync2  <= sync1;
      edge_q <= sync2;
    end
  end

  assign edge_vec = sync2 & ~edge_q;
  assign ref_nx   = ref_cnt + CW'(1);

  // Pick the rising-edge pulse of the latched channel
  always_comb begin
    sel_pulse = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_q == SW'(i)) sel_pulse = edge_vec[i];
    end
  end

`ifdef FREQ_METER_TIMEOUT_EN
  localparam int TW = $clog2(TO_LEN + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_LEN - 1);

  logic [TW-1:0] to_cnt;

  // Watchdog: cleared in IDLE and on every selected edge, counts while waiting for edges
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == IDLE || sel_pulse) begin
      to_cnt <= '0;
    end else if (state == ARM || state == GATE) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  assign to_hit = (state == ARM || state == GATE) && !sel_pulse && (to_cnt == TO_LAST);
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  // Measurement FSM; priority inside the gate: abort, closing edge, saturation, timeout
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      sig_cnt   <= '0;
      ref_cnt   <= '0;
      res_ch    <= '0;
      overflow  <= 1'b0;
      ch_q      <= '0;
      gl_q      <= '0;
`ifdef FREQ_METER_TIMEOUT_EN
      timeout   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ARM;
            busy     <= 1'b1;
            ch_q     <= ch_sel;
            res_ch   <= ch_sel;
            gl_q     <= gate_len;
            sig_cnt  <= '0;
            ref_cnt  <= '0;
            overflow <= 1'b0;
`ifdef FREQ_METER_TIMEOUT_EN
            timeout  <= 1'b0;
`endif
          end
        end
        ARM: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (sel_pulse) begin
            state   <= GATE;
            sig_cnt <= '0;
            ref_cnt <= '0;
          end else if (to_hit) begin
            state     <= DONE;
            res_valid <= 1'b1;
`ifdef FREQ_METER_TIMEOUT_EN
            timeout   <= 1'b1;
`endif
          end
        end
        GATE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            ref_cnt <= ref_nx;
            if (sel_pulse) sig_cnt <= sig_cnt + CW'(1);
            if (sel_pulse && ref_nx >= gl_q) begin
              state     <= DONE;
              res_valid <= 1'b1;
            end else if (ref_nx == CNT_MAX) begin
              state     <= DONE;
              res_valid <= 1'b1;
              overflow  <= 1'b1;
            end else if (to_hit) begin
              state     <= DONE;
              res_valid <= 1'b1;
`ifdef FREQ_METER_TIMEOUT_EN
              timeout   <= 1'b1;
`endif
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            res_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
